// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch port and a data port.
// Latency: grants are combinational; every granted access gets exactly one response one cycle later.
// Backpressure: the losing requester sees gnt low and must hold its request; the pending response is dropped on reset.
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration; by default data has fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // instruction-fetch port (read-only)
  input  logic                    instr_req_i,
  input  logic [31:0]             instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  output logic                    instr_err_o,
  // data port
  input  logic                    data_req_i,
  input  logic [31:0]             data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o,
  // shared memory
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  // contention statistics
  output logic [31:0]             instr_wait_cnt_o,
  output logic [31:0]             data_wait_cnt_o
);

  // Response owner encoding, loaded at every grant and consumed one cycle later.
  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_INSTR = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;

  logic        w_instr_in_range;
  logic        w_data_in_range;
  logic        w_instr_gnt;
  logic        w_data_gnt;

  logic [1:0]  r_owner;
  logic        r_err;
  logic        r_we;
  logic [31:0] r_instr_wait;
  logic [31:0] r_data_wait;

  // Anything above the memory window is an error that never reaches the memory.
  assign w_instr_in_range = ((instr_addr_i >> ADDR_WIDTH) == 32'd0);
  assign w_data_in_range  = ((data_addr_i  >> ADDR_WIDTH) == 32'd0);

`ifdef MEM_ARBITER_RR_EN
  // 1 = data was the most recent winner; reset leaves instruction as last winner so data wins first.
  logic r_last_data;

  // Round-robin: on contention the requester that did not win last time gets the grant.
  always_comb begin
    w_instr_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
        w_data_gnt  = ~r_last_data;
        w_instr_gnt = r_last_data;
      end else begin
        w_data_gnt  = data_req_i;
        w_instr_gnt = instr_req_i;
      end
    end
  end

  // Pointer moves only when someone is actually granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_data <= 1'b0;
    end else if (w_data_gnt) begin
      r_last_data <= 1'b1;
    end else if (w_instr_gnt) begin
      r_last_data <= 1'b0;
    end
  end
`else
  // Fixed priority: data accesses always beat instruction fetches.
  always_comb begin
    w_instr_gnt = 1'b0;
    w_data_gnt  = 1'b0;
    if (!rst_i) begin
      w_data_gnt  = data_req_i;
      w_instr_gnt = instr_req_i & ~data_req_i;
    end
  end
`endif

  assign instr_gnt_o = w_instr_gnt;
  assign data_gnt_o  = w_data_gnt;

  // Steer the winning request onto the memory port; out-of-range wins leave the strobe low.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (w_instr_gnt) begin
      mem_req_o  = w_instr_in_range;
      mem_addr_o = instr_addr_i[ADDR_WIDTH-1:0];
      mem_be_o   = '1;
    end else if (w_data_gnt) begin
      mem_req_o   = w_data_in_range;
      mem_addr_o  = data_addr_i[ADDR_WIDTH-1:0];
      mem_we_o    = data_we_i & w_data_in_range;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // Remember who owns next cycle's response, whether it is an error and whether it was a write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end else if (w_instr_gnt) begin
      r_owner <= OWN_INSTR;
      r_err   <= ~w_instr_in_range;
      r_we    <= 1'b0;
    end else if (w_data_gnt) begin
      r_owner <= OWN_DATA;
      r_err   <= ~w_data_in_range;
      r_we    <= data_we_i;
    end else begin
      r_owner <= OWN_NONE;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
    end
  end

  // Responses are masked while reset is held so a response in flight at reset never escapes.
  assign instr_rvalid_o = ~rst_i & (r_owner == OWN_INSTR);
  assign data_rvalid_o  = ~rst_i & (r_owner == OWN_DATA);
  assign instr_err_o    = instr_rvalid_o & r_err;
  assign data_err_o     = data_rvalid_o & r_err;
  assign instr_rdata_o  = (instr_rvalid_o && !r_err) ? mem_rdata_i : '0;
  assign data_rdata_o   = (data_rvalid_o && !r_err && !r_we) ? mem_rdata_i : '0;

  // Saturating counts of cycles each requester spent waiting for a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instr_wait <= '0;
      r_data_wait  <= '0;
    end else begin
      if (instr_req_i && !w_instr_gnt && (r_instr_wait != 32'hFFFF_FFFF)) begin
        r_instr_wait <= r_instr_wait + 32'd1;
      end
      if (data_req_i && !w_data_gnt && (r_data_wait != 32'hFFFF_FFFF)) begin
        r_data_wait <= r_data_wait + 32'd1;
      end
    end
  end

  assign instr_wait_cnt_o = r_instr_wait;
  assign data_wait_cnt_o  = r_data_wait;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic against a word-level reference model.
// Expected responses are queued at grant time and checked by an independent monitor one cycle later.
// Build with or without MEM_ARBITER_RR_EN; the arbitration model follows the same macro.
module tb_mem_arbiter;

  localparam int AW    = 16;
  localparam int WORDS = 2 ** (AW - 2);

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_be_i;
  logic        mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic [31:0] instr_wait_cnt_o, data_wait_cnt_o;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .instr_wait_cnt_o(instr_wait_cnt_o), .data_wait_cnt_o(data_wait_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Initial memory contents, shared by the memory environment and the reference model.
  function automatic logic [31:0] pat(input int idx);
    return (32'(idx) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory environment: a plain synchronous RAM answering the arbiter's memory port.
  logic [31:0] env_mem [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) env_mem[mem_addr_o[AW-1:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata_i <= env_mem[mem_addr_o[AW-1:2]];
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [int];
  logic [31:0] m_iwait = 0;
  logic [31:0] m_dwait = 0;
`ifdef MEM_ARBITER_RR_EN
  bit m_last_data = 0;
`endif

  typedef struct {
    int          who;   // 1 = instruction port, 2 = data port
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return 64'(a) < (64'd1 << AW);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int idx = int'(a[AW-1:2]);
    return ref_mem.exists(idx) ? ref_mem[idx] : pat(idx);
  endfunction

  // One bus cycle: drive, check grants and memory port mid-cycle, predict response, check counters.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                      input bit we, input logic [3:0] be, input logic [31:0] wd,
                      output bit gi, output bit gd);
    exp_t e;
    logic [31:0] w;
    bit inr;
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_addr_i = da; data_we_i = we; data_be_i = be; data_wdata_i = wd;
    @(negedge clk);
    gd = dr;
    gi = ir && !dr;
`ifdef MEM_ARBITER_RR_EN
    if (ir && dr) begin
      gd = !m_last_data;
      gi = m_last_data;
    end
    if (gi || gd) m_last_data = gd;
`endif
    chk("instr_gnt", 32'(instr_gnt_o), 32'(gi));
    chk("data_gnt", 32'(data_gnt_o), 32'(gd));
    if (gi) begin
      inr = in_range(ia);
      chk("mem_req_instr", 32'(mem_req_o), 32'(inr));
      if (inr) begin
        chk("mem_addr_instr", 32'(mem_addr_o), ia);
        chk("mem_we_instr", 32'(mem_we_o), 32'd0);
        chk("mem_be_instr", 32'(mem_be_o), 32'hF);
      end
      e.who = 1; e.err = !inr; e.rdata = inr ? ref_rd(ia) : 32'd0; e.due = cyc + 1;
      sb.push_back(e);
    end else if (gd) begin
      inr = in_range(da);
      chk("mem_req_data", 32'(mem_req_o), 32'(inr));
      if (inr) begin
        chk("mem_addr_data", 32'(mem_addr_o), da);
        chk("mem_we_data", 32'(mem_we_o), 32'(we));
        chk("mem_be_data", 32'(mem_be_o), 32'(be));
        if (we) chk("mem_wdata", mem_wdata_o, wd);
      end
      e.who = 2; e.err = !inr; e.rdata = (inr && !we) ? ref_rd(da) : 32'd0; e.due = cyc + 1;
      sb.push_back(e);
      if (inr && we) begin
        w = ref_rd(da);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        ref_mem[int'(da[AW-1:2])] = w;
      end
    end else begin
      chk("mem_req_idle", 32'(mem_req_o), 32'd0);
    end
    if (ir && !gi && m_iwait != 32'hFFFF_FFFF) m_iwait++;
    if (dr && !gd && m_dwait != 32'hFFFF_FFFF) m_dwait++;
    @(posedge clk); #1;
    chk("instr_wait_cnt", instr_wait_cnt_o, m_iwait);
    chk("data_wait_cnt", data_wait_cnt_o, m_dwait);
  endtask

  // Hold reset for n cycles with the given requests asserted; everything visible must stay quiet.
  task automatic do_reset(input int n, input bit ir, input bit dr);
    rst_i = 1'b1;
    instr_req_i = ir; instr_addr_i = 32'h0;
    data_req_i = dr; data_addr_i = 32'h4; data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = 32'h0;
    sb.delete();
    repeat (n) begin
      @(negedge clk);
      chk("rst_instr_gnt", 32'(instr_gnt_o), 32'd0);
      chk("rst_data_gnt", 32'(data_gnt_o), 32'd0);
      chk("rst_instr_rvalid", 32'(instr_rvalid_o), 32'd0);
      chk("rst_data_rvalid", 32'(data_rvalid_o), 32'd0);
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_errs", {30'd0, instr_err_o, data_err_o}, 32'd0);
      chk("rst_instr_rdata", instr_rdata_o, 32'd0);
      chk("rst_data_rdata", data_rdata_o, 32'd0);
      @(posedge clk); #1;
    end
    chk("rst_instr_wait", instr_wait_cnt_o, 32'd0);
    chk("rst_data_wait", data_wait_cnt_o, 32'd0);
    rst_i = 1'b0;
    instr_req_i = 1'b0;
    data_req_i = 1'b0;
    m_iwait = 0;
    m_dwait = 0;
`ifdef MEM_ARBITER_RR_EN
    m_last_data = 0;
`endif
  endtask

  // Monitor: every rvalid must match the oldest queued expectation, in the cycle it is due.
  always @(negedge clk) begin
    exp_t e;
    if (instr_rvalid_o || data_rvalid_o) begin
      if (sb.size() == 0) begin
        chk("rvalid_without_grant", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", cyc, e.due);
        chk("rsp_owner", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'(e.who));
        if (e.who == 1) begin
          chk("instr_rdata", instr_rdata_o, e.rdata);
          chk("instr_err", 32'(instr_err_o), 32'(e.err));
        end else begin
          chk("data_rdata", data_rdata_o, e.rdata);
          chk("data_err", 32'(data_err_o), 32'(e.err));
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("rvalid_missing", {30'd0, instr_rvalid_o | data_rvalid_o}, 32'd1);
      void'(sb.pop_front());
    end
  end

  function automatic logic [31:0] raddr();
    int r = $urandom_range(0, 9);
    if (r == 0) return 32'h0001_0000 | $urandom;
    if (r == 1) return 32'($urandom_range(0, 65535));
    return 32'($urandom_range(0, 31) * 4);
  endfunction

  initial begin
    bit gi, gd, pi, pd, pwe, need_i, need_d;
    logic [31:0] pia, pda, pwd;
    logic [3:0] pbe;

    for (int i = 0; i < WORDS; i++) env_mem[i] = pat(i);
    mem_rdata_i = 32'h0;
    rst_i = 1'b1;
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_addr_i = 0;
    data_we_i = 0; data_be_i = 0; data_wdata_i = 0;
    @(posedge clk); #1;
    do_reset(3, 1'b1, 1'b1);

    // Plain fetch, then a partial write followed by a read-back of the merged word.
    step(1, 32'h3000, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 1, 32'h0010, 1, 4'h3, 32'hDEAD_BEEF, gi, gd);
    step(0, 0, 1, 32'h0010, 0, 4'hF, 0, gi, gd);
    // Out-of-range data read and out-of-range fetch.
    step(0, 0, 1, 32'h0001_0000, 0, 4'hF, 0, gi, gd);
    step(1, 32'h8000_0000, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Four cycles of contention from a fresh reset.
    do_reset(1, 1'b0, 1'b0);
    repeat (4) step(1, 32'h0040, 1, 32'h0020, 0, 4'hF, 0, gi, gd);
`ifdef MEM_ARBITER_RR_EN
    chk("contention_instr_wait", instr_wait_cnt_o, 32'd2);
`else
    chk("contention_instr_wait", instr_wait_cnt_o, 32'd4);
`endif
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Reset in the cycle after a fetch grant drops its response.
    step(1, 32'h0100, 0, 0, 0, 0, 0, gi, gd);
    do_reset(2, 1'b1, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);

    // Randomized traffic; an ungranted requester holds its request unchanged.
    need_i = 1; need_d = 1; pi = 0; pd = 0;
    pia = 0; pda = 0; pwd = 0; pwe = 0; pbe = 0;
    for (int k = 0; k < 1500; k++) begin
      if (need_i) begin
        pi = ($urandom_range(0, 2) != 0);
        pia = raddr();
      end
      if (need_d) begin
        pd = ($urandom_range(0, 2) != 0);
        pda = raddr();
        pwe = $urandom_range(0, 1) == 1;
        pbe = 4'($urandom_range(0, 15));
        pwd = $urandom;
      end
      if (k == 700) begin
        do_reset(1, pi, pd);
        need_i = 1; need_d = 1;
      end else begin
        step(pi, pia, pd, pda, pwe, pbe, pwd, gi, gd);
        need_i = gi || !pi;
        need_d = gd || !pd;
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    step(0, 0, 0, 0, 0, 0, 0, gi, gd);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, byte-address width of the shared memory (memory size 2**ADDR_WIDTH bytes).
REQ-002 Parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 instr_req_i  input  1  instruction-fetch request (read-only).
REQ-006 instr_addr_i  input  32  instruction byte address.
REQ-007 instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 instr_rvalid_o  output  1  fetch response valid.
REQ-009 instr_rdata_o  output  32  fetched word.
REQ-010 instr_err_o  output  1  fetch response is an out-of-range error; qualified by instr_rvalid_o.
REQ-011 data_req_i  input  1  data request.
REQ-012 data_addr_i  input  32  data byte address.
REQ-013 data_we_i  input  1  1 = write, 0 = read.
REQ-014 data_be_i  input  4  byte enables.
REQ-015 data_wdata_i  input  32  write data.
REQ-016 data_gnt_o  output  1  data request accepted this cycle.
REQ-017 data_rvalid_o  output  1  data response valid (reads and writes).
REQ-018 data_rdata_o  output  32  read data.
REQ-019 data_err_o  output  1  data response is an out-of-range error; qualified by data_rvalid_o.
REQ-020 mem_req_o  output  1  memory access strobe.
REQ-021 mem_addr_o  output  ADDR_WIDTH  memory byte address.
REQ-022 mem_we_o  output  1  memory write enable.
REQ-023 mem_be_o  output  4  memory byte enables.
REQ-024 mem_wdata_o  output  32  memory write data.
REQ-025 mem_rdata_i  input  32  memory read data, valid one cycle after mem_req_o with mem_we_o = 0.
REQ-026 instr_wait_cnt_o  output  32  count of cycles with instr_req_i high and instr_gnt_o low.
REQ-027 data_wait_cnt_o  output  32  count of cycles with data_req_i high and data_gnt_o low.

Function
REQ-028 Grants are combinational from the same-cycle requests; at most one of instr_gnt_o/data_gnt_o is high in any cycle.
REQ-029 A request is in range iff addr[31:ADDR_WIDTH] == 0.
REQ-030 A granted in-range request drives mem_req_o = 1 and mem_addr_o = addr[ADDR_WIDTH-1:0]; the fetch path forces mem_we_o = 0 and mem_be_o = 4'hF.
REQ-031 A granted out-of-range request keeps mem_req_o = 0 and gets a response one cycle later with err = 1 and rdata = 0.
REQ-032 Response latency is exactly one cycle after the grant: exactly one rvalid pulse goes to the granted requester, carrying mem_rdata_i for reads and rdata = 0 for writes.
REQ-033 A response owner register (NONE/INSTR/DATA) plus an err flag is loaded at each grant; it selects the rvalid/rdata/err routing in the next cycle.
REQ-034 Back-to-back grants on consecutive cycles are allowed; the pipeline holds one outstanding response.
REQ-035 Ungranted requesters hold request and address stable until granted; the arbiter does not check this.
REQ-036 Wait counters saturate at 32'hFFFF_FFFF and do not wrap.

Reset
REQ-037 While rst_i is high, both grants, both rvalids, mem_req_o and both errs are 0, and all rdata outputs are 0.
REQ-038 Reset clears the owner to NONE, the round-robin pointer to INSTR-last, and both wait counters to 0.
REQ-039 A response pending when rst_i asserts is dropped; no rvalid is issued after reset.

Configuration
REQ-040 With MEM_ARBITER_RR_EN defined, simultaneous requests are granted round-robin; the requester not granted last wins, and the pointer updates only on a grant.
REQ-041 Without MEM_ARBITER_RR_EN, data requests always win over fetch; no pointer state exists.

Verification
REQ-042 Fetch only, addr 0x3000 -> instr_gnt_o high the same cycle, mem_addr_o = 0x3000; next cycle instr_rvalid_o = 1 with the stored word.
REQ-043 Data write 0xDEADBEEF to 0x0010 with be=4'h3, then a read of 0x0010 -> data_rvalid_o after each access; the read returns the low halfword BEEF merged with the prior memory contents.
REQ-044 Both requesting for 4 cycles -> with RR_EN, grants alternate D,I,D,I; without it, grants are D,D,D,D and instr_wait_cnt_o = 4.
REQ-045 Data read at 0x0001_0000 with ADDR_WIDTH=16 -> mem_req_o stays 0; next cycle data_rvalid_o = 1, data_err_o = 1, data_rdata_o = 0.
REQ-046 rst_i asserted the cycle after a fetch grant -> no instr_rvalid_o pulse; the counters and owner read zero after reset.
